// File: rtl/rr_resource_arbiter_if.sv
// rtl/rr_resource_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface rr_resource_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin arbiter with per-grant hold limit
module rr_resource_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_resource_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]     state_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic           busy_q;
  logic           timeout_q;
  logic [IDW-1:0] last_q;
  logic [CW-1:0]  hold_cnt_q;

  logic           found;
  logic [IDW-1:0] sel;
  logic           rel_done;
  logic           rel_drop;
  logic           rel_limit;

  // Rotating scan starting just after the last owner, so the previous owner comes last.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
  end

  assign rel_done  = bus.done[grant_id_q];
  assign rel_drop  = !bus.req[grant_id_q];
  assign rel_limit = (hold_cnt_q == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= IDW'(N - 1);
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_q    <= ST_GRANT;
            grant_q    <= N'(1) << sel;
            grant_id_q <= sel;
            busy_q     <= 1'b1;
            last_q     <= sel;
            hold_cnt_q <= CW'(1);
          end
        end
        ST_GRANT: begin
          // A voluntary release wins over the hold limit, so timeout stays low then.
          if (rel_done || rel_drop || rel_limit) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            timeout_q  <= !(rel_done || rel_drop);
          end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          grant_q    <= '0;
          busy_q     <= 1'b0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule
